joydir_filter: RTL

Parametrised multi-player joystick conditioner, sitting between the input merge (keyboard OR gamepad) and the game core's active-low `in0`/`in1` assembly. Per player it rotates the 4 direction bits for screen orientation, synchronises and debounces them, then applies a selectable direction policy:

- pass-through
- 4-way last-pressed
- 4-way first-held
- 8-way with opposite-cancel

Outputs are registered and active-high. Inversion to the core's active-low convention happens outside this block.

---
 rtl/joydir_filter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/joydir_filter.sv
// Multi-player joystick direction conditioner: rotate, synchronise, debounce,
// then apply a 4-way / 8-way direction policy. Outputs are active-high and registered.

module joydir_player #(
   parameter int DB_TICKS = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ce,
   input  logic [1:0] mode,
   input  logic [1:0] rot,
   input  logic       mode_chg,
   input  logic [3:0] raw,
   output logic [3:0] dir,
   output logic       chg
);
   localparam int CW = $clog2(DB_TICKS + 1);
   localparam logic [CW-1:0] DB_MAX = CW'(DB_TICKS);

   logic [3:0]         rdir, s1, s2, d, dq, nw, mask, mask_n, out_n;
   logic [3:0][CW-1:0] cnt;

   function automatic logic [3:0] hi(input logic [3:0] x);
      if (x[3])      return 4'b1000;
      else if (x[2]) return 4'b0100;
      else if (x[1]) return 4'b0010;
      else if (x[0]) return 4'b0001;
      else           return 4'b0000;
   endfunction

   // bit order {up, down, left, right}
   always_comb begin
      case (rot)
         2'd1:    rdir = {raw[1], raw[0], raw[2], raw[3]};
         2'd2:    rdir = {raw[2], raw[3], raw[0], raw[1]};
         2'd3:    rdir = {raw[0], raw[1], raw[3], raw[2]};
         default: rdir = raw;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= rdir;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         d   <= '0;
      end else if (ce) begin
         for (int b = 0; b < 4; b++) begin
            if (s2[b] != d[b]) begin
               if (cnt[b] + CW'(1) == DB_MAX) begin
                  d[b]   <= ~d[b];
                  cnt[b] <= '0;
               end else begin
                  cnt[b] <= cnt[b] + CW'(1);
               end
            end else begin
               cnt[b] <= '0;
            end
         end
      end
   end

   always_comb begin
      nw     = d & ~dq;
      mask_n = mask;
      case (mode)
         2'd1: begin
            if (nw != 4'h0)              mask_n = hi(nw);
            else if ((d & mask) == 4'h0) mask_n = 4'hF;
         end
         2'd2: begin
            if (mask == 4'hF && d != 4'h0) mask_n = hi(d);
            else if ((d & mask) == 4'h0)   mask_n = 4'hF;
         end
         default: mask_n = 4'hF;
      endcase
      if (mode_chg) mask_n = 4'hF;

      out_n = d & mask_n;
      if (mode == 2'd3) begin
         out_n = d;
         // opposite directions cancel each other
         if (d[3] && d[2]) out_n[3:2] = 2'b00;
         if (d[1] && d[0]) out_n[1:0] = 2'b00;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dq   <= '0;
         mask <= 4'hF;
         dir  <= '0;
         chg  <= 1'b0;
      end else begin
         dq   <= d;
         mask <= mask_n;
         dir  <= out_n;
         chg  <= (out_n != dir);
      end
   end
endmodule

module joydir_filter #(
   parameter int PLAYERS  = 2,
   parameter int DB_TICKS = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 ce,
   input  logic [1:0]           mode,
   input  logic [1:0]           rot,
   input  logic [4*PLAYERS-1:0] in_dir,
   output logic [4*PLAYERS-1:0] out_dir,
   output logic [PLAYERS-1:0]   chg
);
   logic [1:0] mode_q;
   logic       mode_chg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) mode_q <= 2'd0;
      else          mode_q <= mode;
   end

   // any mode change resets every player's mask to idle
   assign mode_chg = (mode != mode_q);

   for (genvar p = 0; p < PLAYERS; p++) begin : g_player
      joydir_player #(.DB_TICKS(DB_TICKS)) u_player (
         .clk      (clk),
         .reset_n  (reset_n),
         .ce       (ce),
         .mode     (mode),
         .rot      (rot),
         .mode_chg (mode_chg),
         .raw      (in_dir[4*p +: 4]),
         .dir      (out_dir[4*p +: 4]),
         .chg      (chg[p])
      );
   end
endmodule
